// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer with valid/ready request and response.
// Optional MULDIV_SPECIAL_FAST_EN: divide-by-zero / signed overflow retire straight from IDLE.
`timescale 1ns/1ps
module muldiv_seq #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  mode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] q,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_e;

  localparam logic [4:0] MUL_LAST = (MUL_LAT > 1) ? 5'(MUL_LAT - 2) : 5'd0;

  state_e      state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [31:0] q_q, q_d;
  logic        rsp_valid_q, rsp_valid_d;

  logic        accept;
  logic [2:0]  op_mode;
  logic [31:0] op_a, op_b;
  logic [63:0] ext_a, ext_b, product;
  logic [31:0] mul_res;
  logic        div_signed, div_zero, div_ovf, special;
  logic [31:0] ovr_res, mag_a, mag_b;
  logic [32:0] rem_sh, diff;
  logic [31:0] quo_fix, rem_fix, div_res;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign q         = q_q;
  assign accept    = req_valid && (state_q == IDLE) && !flush;

  // In IDLE the live inputs feed the datapath so single-edge paths see the new operands.
  assign op_mode = (state_q == IDLE) ? mode : mode_q;
  assign op_a    = (state_q == IDLE) ? a    : a_q;
  assign op_b    = (state_q == IDLE) ? b    : b_q;

  always_comb begin
    ext_a   = {{32{op_a[31] & (op_mode[1:0] != 2'b11)}}, op_a};
    ext_b   = {{32{op_b[31] & ~op_mode[1]}}, op_b};
    product = ext_a * ext_b;
    mul_res = (op_mode[1:0] == 2'b00) ? product[31:0] : product[63:32];
  end

  always_comb begin
    div_signed = ~op_mode[0];
    div_zero   = (op_b == '0);
    div_ovf    = div_signed && (op_a == 32'h8000_0000) && (op_b == '1);
    special    = div_zero || div_ovf;
    if (div_zero) ovr_res = op_mode[1] ? op_a : '1;
    else          ovr_res = op_mode[1] ? '0 : 32'h8000_0000;
    mag_a = (div_signed && op_a[31]) ? -op_a : op_a;
    mag_b = (div_signed && op_b[31]) ? -op_b : op_b;
  end

  // Restoring step: bit 32 of the difference is the borrow, i.e. "does not fit".
  always_comb begin
    rem_sh  = {rem_q, quo_q[31]};
    diff    = rem_sh - {1'b0, dvs_q};
    quo_fix = (div_signed && (op_a[31] ^ op_b[31])) ? -quo_q : quo_q;
    rem_fix = (div_signed && op_a[31]) ? -rem_q : rem_q;
    div_res = op_mode[1] ? rem_fix : quo_fix;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    q_d         = q_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d = mode;
          a_d    = a;
          b_d    = b;
          cnt_d  = '0;
          rem_d  = '0;
          quo_d  = mag_a;
          dvs_d  = mag_b;
          if (mode[2]) begin
`ifdef MULDIV_SPECIAL_FAST_EN
            if (special) begin
              state_d = DONE;
              q_d     = ovr_res;
            end else begin
              state_d = DIV;
            end
`else
            state_d = DIV;
`endif
          end else if (MUL_LAT == 1) begin
            state_d = DONE;
            q_d     = mul_res;
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: begin
        if (cnt_q == MUL_LAST) begin
          state_d = DONE;
          q_d     = mul_res;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DIV: begin
        if (!diff[32]) rem_d = diff[31:0];
        else           rem_d = rem_sh[31:0];
        quo_d = {quo_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        q_d     = special ? ovr_res : div_res;
      end
      DONE: begin
        if (rsp_valid_q && rsp_ready) state_d = IDLE;
        else                          rsp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_q         <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      q_q         <= q_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with a queue scoreboard of expected results.
`timescale 1ns/1ps
module tb_muldiv_seq;

  localparam logic [2:0] M_MUL = 3'b000, M_MULH = 3'b001, M_MULHSU = 3'b010, M_MULHU = 3'b011;
  localparam logic [2:0] M_DIV = 3'b100, M_DIVU = 3'b101, M_REM = 3'b110, M_REMU = 3'b111;
`ifdef MULDIV_SPECIAL_FAST_EN
  localparam int SPL = 1;
`else
  localparam int SPL = 34;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  mode = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] q;
  logic        busy;

  typedef struct {
    logic [31:0] q;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  muldiv_seq #(.MUL_LAT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .q        (q),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one op, wait for its response, compare with the scoreboard, hold, then retire.
  task automatic run_op(input string tag, input logic [2:0] m, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [31:0] exp, input int lat,
                        input int hold);
    exp_t e;
    int   n;
    bit   seen;
    e.q   = exp;
    e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    check({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    mode = m;
    a = ia;
    b = ib;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mode = 3'($urandom);
    a = $urandom;
    b = $urandom;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (rsp_valid) seen = 1;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_lat"}, seen ? n : -1, e.lat);
      check({tag, "_q"}, q, e.q);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        a = $urandom;
        b = $urandom;
        @(posedge clk);
        #1;
        check({tag, "_hold_v"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, "_hold_q"}, q, e.q);
        check({tag, "_hold_rdy"}, {31'b0, req_ready}, 32'd0);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_ret_v"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_ret_rdy"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_v;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_q", q, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Multiplies
    run_op("mul", M_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 0);
    run_op("mulhu", M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0);
    run_op("mulhsu", M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0);
    run_op("mulh", M_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 0);

    // Divides and remainders
    run_op("div", M_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    run_op("rem", M_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    run_op("divu", M_DIVU, 32'd100, 32'd7, 32'd14, 34, 0);
    run_op("remu", M_REMU, 32'd100, 32'd7, 32'd2, 34, 0);
    run_op("div_negb", M_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0);
    run_op("rem_negb", M_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0);

    // Special cases
    run_op("divu_z", M_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPL, 0);
    run_op("remu_z", M_REMU, 32'd5, 32'd0, 32'd5, SPL, 0);
    run_op("div_z", M_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, SPL, 0);
    run_op("rem_z", M_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SPL, 0);
    run_op("div_ovf", M_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPL, 0);
    run_op("rem_ovf", M_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPL, 0);

    // Backpressure with toggling operands
    run_op("bp_divu", M_DIVU, 32'd100, 32'd7, 32'd14, 34, 5);

    // Flush at iteration 10 of a divide
    @(negedge clk);
    req_valid = 1'b1;
    mode = M_DIV;
    a = 32'd1000;
    b = 32'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("flush_req_ready", {31'b0, req_ready}, 32'd1);
    cnt_v = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (rsp_valid) cnt_v++;
    end
    check("flush_no_rsp", cnt_v, 32'd0);
    run_op("mul_after_flush", M_MUL, 32'd3, 32'd4, 32'd12, 2, 0);

    // Flush and request together in IDLE: nothing accepted
    @(negedge clk);
    flush = 1'b1;
    req_valid = 1'b1;
    mode = M_MUL;
    a = 32'd9;
    b = 32'd9;
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_valid = 1'b0;
    check("flush_req_busy", {31'b0, busy}, 32'd0);
    cnt_v = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (rsp_valid) cnt_v++;
    end
    check("flush_req_no_rsp", cnt_v, 32'd0);

    // Reset pulsed during a multiply
    @(negedge clk);
    req_valid = 1'b1;
    mode = M_MUL;
    a = 32'd5;
    b = 32'd6;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("mul_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_mid_q", q, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    cnt_v = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (rsp_valid) cnt_v++;
    end
    check("rst_mid_no_rsp", cnt_v, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide unit. It accepts one operation at a time from the execute stage over a valid/ready handshake and captures the operands. Multiplies run for a fixed pipelined latency; divides and remainders run a 32-iteration restoring divider followed by a sign-fix step. The RISC-V divide-by-zero and overflow results are produced here, and the result is held until the writeback side accepts it.

## Interface

- `MUL_LAT`, default 2, cycles from accept to result for multiply ops; legal range 1..4.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `flush`  in  1  abort in-flight op; no response is produced
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept; high only in IDLE
- `mode`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  32  rs1 operand
- `b`  in  32  rs2 operand
- `rsp_valid`  out  1  result valid; held until taken
- `rsp_ready`  in  1  consumer accepts result
- `q`  out  32  result
- `busy`  out  1  state != IDLE

## Operation

- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: `req_valid && req_ready` at an edge captures `mode`, `a` and `b`. Later input changes are ignored.
- Multiply:
  - Full 64-bit product. MUL and MULH use signed×signed; MULHSU uses signed `a` × zero-extended `b`; MULHU uses unsigned×unsigned.
  - MUL returns bits [31:0]. The other three return bits [63:32].
  - IDLE→MUL; a counter runs MUL_LAT−1 cycles, then MUL→DONE. With MUL_LAT=1, IDLE→DONE directly.
- Divide:
  - For signed modes, the divider works on operand magnitudes. 0x80000000 is treated as unsigned 2^31.
  - DIV runs a 32-iteration shift/subtract, one quotient bit per cycle, producing a 32-bit quotient and remainder. Then DIV→FIX.
  - FIX applies signs: the quotient is negated if the operand signs differ (signed only); the remainder takes the sign of `a`. Then FIX→DONE.
- Special cases override the result:
  - b==0: DIV and DIVU return 0xFFFFFFFF; REM and REMU return `a`.
  - Signed overflow (a==0x80000000, b==0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- DONE: `rsp_valid`=1 and `q` is stable. On `rsp_valid && rsp_ready`, DONE→IDLE. `req_ready` stays low in DONE, so there is no accept in the same cycle as retire.
- Flush: any state→IDLE at the next edge. `rsp_valid` drops and the result is discarded. If `flush` and `req_valid` arrive together in IDLE, flush wins and nothing is accepted.

## Timing

- Reset values: state IDLE, `rsp_valid`=0, `q`=0, `busy`=0, iteration counter 0. `req_ready`=1 from the first cycle after reset.
- `rst` mid-operation aborts like `flush`; `rsp_valid` is 0 the cycle after.
- Latencies, with accept at edge E0:
  - Multiply: `rsp_valid` rises after edge E0+MUL_LAT.
  - Divide/remainder: 32 iteration edges, 1 FIX edge, then DONE. `rsp_valid` rises after edge E0+34.
  - Special cases: see Configuration.
- Throughput is one op in flight. The next accept is no earlier than the cycle after retire.
- `req_ready` and `busy` are decoded directly from state. `q` and `rsp_valid` are registered.

## Configuration

- `MULDIV_SPECIAL_FAST_EN` defined:
  - Divide-by-zero and signed-overflow are detected at accept.
  - The state goes IDLE→DONE directly with the override result.
  - `rsp_valid` rises after E0+1.
- Undefined:
  - Special cases run the full DIV/FIX sequence.
  - FIX substitutes the override result, so `rsp_valid` rises after E0+34.
  - Results are identical either way; only latency differs.

## Test plan

- MUL, MUL_LAT=2, a=7, b=0xFFFFFFFD → `q`=0xFFFFFFEB, with `rsp_valid` exactly 2 cycles after accept. Also MULHU, a=b=0xFFFFFFFF → `q`=0xFFFFFFFE.
- MULHSU, a=0xFFFFFFFF, b=0xFFFFFFFF → `q`=0xFFFFFFFF. Also MULH, a=0x80000000, b=0x80000000 → `q`=0x40000000.
- DIV, a=0xFFFFFFF9 (−7), b=2 → `q`=0xFFFFFFFD, 34 cycles after accept. Also REM with the same operands → `q`=0xFFFFFFFF. Also DIVU, a=100, b=7 → `q`=14.
- DIVU, a=5, b=0 → `q`=0xFFFFFFFF. Also REMU, a=5, b=0 → `q`=5. Also DIV 0x80000000/0xFFFFFFFF → `q`=0x80000000; REM of the same → `q`=0. Latency is 1 with `MULDIV_SPECIAL_FAST_EN` and 34 without.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after DONE → `rsp_valid` and `q` remain stable and `req_ready`=0. Toggling `a`/`b` meanwhile has no effect. Retire occurs on the first cycle with `rsp_ready`=1.
- Flush at iteration 10 of a DIV → no response; `req_ready`=1 on the next cycle. A subsequent MUL a=3, b=4 returns 12. Also `rst` pulsed during MUL → all outputs at reset values.
